// File: rtl/mem_arbiter_multi.sv
// NUM_CH-channel arbiter onto the byte-serial RAM/IO bus: byte/half/word reads and writes,
// fixed or round-robin priority, flush abort of masked reads, IO write stalls.
module mem_arbiter_multi #(
   parameter int unsigned        NUM_CH     = 3,
   parameter int unsigned        ARB_MODE   = 0,
   parameter logic [NUM_CH-1:0]  FLUSH_MASK = {NUM_CH{1'b1}}
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 flush,
   input  logic [NUM_CH-1:0]    req_valid,
   input  logic [NUM_CH-1:0]    req_wr,
   input  logic [2*NUM_CH-1:0]  req_size,
   input  logic [NUM_CH-1:0]    req_signed,
   input  logic [32*NUM_CH-1:0] req_addr,
   input  logic [32*NUM_CH-1:0] req_wdata,
   output logic [NUM_CH-1:0]    resp_valid,
   output logic [32*NUM_CH-1:0] resp_data,
   input  logic                 io_buffer_full,
   input  logic [7:0]           mem_din,
   output logic [7:0]           mem_dout,
   output logic [31:0]          mem_a,
   output logic                 mem_wr
);

   localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {IDLE, ADDR, TAIL, IOWAIT} state_t;

   state_t            state;
   logic [CW-1:0]     ch_q, rr_ptr, grant_ch;
   logic [31:0]       addr_q, wdata_q, g_addr, g_wdata, rdata;
   logic [1:0]        idx, idx_nxt, last_q, g_size, din_i;
   logic              txn_wr, sgn_q, last_rd, din_v;
   logic              grant_ok, g_wr, g_sgn, io_stall, ext, flush_hit;
   logic [23:0]       rbuf;
   logic [NUM_CH-1:0] elig, ch_oh;
   logic [CW:0]       rr_sum;

   function automatic logic [1:0] last_idx(input logic [1:0] s);
      case (s)
         2'b00:   return 2'd0;
         2'b01:   return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   // Winner selection; a channel being answered this cycle is still holding a stale request.
   always_comb begin
      elig     = req_valid & ~resp_valid;
      grant_ok = 1'b0;
      grant_ch = '0;
      rr_sum   = '0;
      if (ARB_MODE == 0) begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (elig[i]) begin
               grant_ok = 1'b1;
               grant_ch = CW'(i);
            end
         end
      end else begin
         for (int k = NUM_CH - 1; k >= 0; k--) begin
            rr_sum = {1'b0, rr_ptr} + (CW + 1)'(k);
            if (rr_sum >= (CW + 1)'(NUM_CH)) rr_sum = rr_sum - (CW + 1)'(NUM_CH);
            if (elig[rr_sum[CW-1:0]]) begin
               grant_ok = 1'b1;
               grant_ch = rr_sum[CW-1:0];
            end
         end
      end
   end

   always_comb begin
      g_wr    = 1'b0;
      g_sgn   = 1'b0;
      g_size  = 2'b00;
      g_addr  = '0;
      g_wdata = '0;
      ch_oh   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_ch == CW'(i)) begin
            g_wr    = req_wr[i];
            g_sgn   = req_signed[i];
            g_size  = req_size[2*i +: 2];
            g_addr  = req_addr[32*i +: 32];
            g_wdata = req_wdata[32*i +: 32];
         end
         ch_oh[i] = (ch_q == CW'(i));
      end
   end

   // Last byte comes straight from mem_din; earlier bytes were captured into rbuf.
   always_comb begin
      ext = sgn_q & mem_din[7];
      case (last_q)
         2'd0:    rdata = {{24{ext}}, mem_din};
         2'd1:    rdata = {{16{ext}}, mem_din, rbuf[7:0]};
         default: rdata = {mem_din, rbuf};
      endcase
   end

   assign idx_nxt   = idx + 2'd1;
   assign flush_hit = flush && !txn_wr && |(FLUSH_MASK & ch_oh);
   assign io_stall  = (state == ADDR) && txn_wr && (addr_q[17:16] == 2'b11) && io_buffer_full;
   assign mem_wr    = (state == ADDR) && txn_wr && rdy && !io_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         resp_valid <= '0;
         resp_data  <= '0;
         mem_a      <= '0;
         mem_dout   <= '0;
         rr_ptr     <= '0;
         idx        <= '0;
         ch_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         last_q     <= '0;
         txn_wr     <= 1'b0;
         sgn_q      <= 1'b0;
         last_rd    <= 1'b0;
         rbuf       <= '0;
         din_v      <= 1'b0;
         din_i      <= '0;
      end else begin
         // RAM answers every cycle, even while frozen, so track which byte mem_din carries.
         din_v <= (state == ADDR) && !txn_wr;
         din_i <= idx;
         if (din_v) begin
            case (din_i)
               2'd0:    rbuf[7:0]   <= mem_din;
               2'd1:    rbuf[15:8]  <= mem_din;
               2'd2:    rbuf[23:16] <= mem_din;
               default: ;
            endcase
         end
         if (rdy) begin
            resp_valid <= '0;
            case (state)
               IDLE: begin
                  if (!flush && grant_ok) begin
                     ch_q    <= grant_ch;
                     addr_q  <= g_addr;
                     wdata_q <= g_wdata;
                     last_q  <= last_idx(g_size);
                     txn_wr  <= g_wr;
                     sgn_q   <= g_sgn;
                     idx     <= '0;
                     if (ARB_MODE != 0)
                        rr_ptr <= (grant_ch == CW'(NUM_CH - 1)) ? '0 : grant_ch + CW'(1);
                     if (g_wr && (g_addr[17:16] == 2'b11) && last_rd) begin
                        state <= IOWAIT;
                     end else begin
                        state    <= ADDR;
                        mem_a    <= g_addr;
                        mem_dout <= g_wdata[7:0];
                        last_rd  <= !g_wr;
                     end
                  end
               end
               IOWAIT: begin
                  state    <= ADDR;
                  mem_a    <= addr_q;
                  mem_dout <= wdata_q[7:0];
                  last_rd  <= 1'b0;
               end
               ADDR: begin
                  if (flush_hit) begin
                     state <= IDLE;
                  end else if (!io_stall) begin
                     if (idx == last_q) begin
                        if (txn_wr) begin
                           resp_valid <= ch_oh;
                           state      <= IDLE;
                        end else begin
                           state <= TAIL;
                        end
                     end else begin
                        idx      <= idx_nxt;
                        mem_a    <= addr_q + 32'(idx_nxt);
                        mem_dout <= 8'(wdata_q >> {idx_nxt, 3'b000});
                     end
                  end
               end
               TAIL: begin
                  state <= IDLE;
                  if (!flush_hit) begin
                     resp_valid <= ch_oh;
                     for (int i = 0; i < NUM_CH; i++)
                        if (ch_oh[i]) resp_data[32*i +: 32] <= rdata;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
